// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   rx_state_t        : receive sequencer states
//   PAR_EVEN/PAR_ODD  : encodings of the PAR_TYP input
//   DEF_DATA_WIDTH    : default number of data bits per frame
//   DEF_PRESCALE_MAX  : default largest oversampling ratio
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int   DEF_DATA_WIDTH   = 8;
    localparam int   DEF_PRESCALE_MAX = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_cnt
// Oversample edge counter and data-bit counter for the UART RX sequencer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_en         : count enable (sequencer outside IDLE); low holds edge count 0
//   i_prescale   : latched oversampling ratio
//   i_bit_clr    : clear the data-bit counter
//   i_bit_inc    : advance the data-bit counter
//   o_edge_cnt   : oversample edge index within the current bit
//   o_bit_cnt    : index of the data bit being received
//   o_bit_end    : high in the cycle where o_edge_cnt == i_prescale-1
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_cnt #(
    parameter int PW = 6,
    parameter int EW = 5,
    parameter int BW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [PW-1:0] i_prescale,
    input  logic          i_bit_clr,
    input  logic          i_bit_inc,
    output logic [EW-1:0] o_edge_cnt,
    output logic [BW-1:0] o_bit_cnt,
    output logic          o_bit_end
);

    logic [EW-1:0] r_edge_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [PW-1:0] w_last_edge;

    // Compare at the wider Prescale width so Prescale=32 yields 31, which
    // still fits the edge counter and wraps it cleanly to 0.
    assign w_last_edge = i_prescale - PW'(1);
    assign o_bit_end   = i_en && (PW'(r_edge_cnt) == w_last_edge);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
        end else if (!i_en || o_bit_end) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + EW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (i_bit_clr) begin
            r_bit_cnt <= '0;
        end else if (i_bit_inc) begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Receive-side sequencer: detects the start edge, drives the sampler enable
// and edge index, and assembles start / data (LSB first) / parity / stop.
//   clk, rst_n   : oversampling clock, asynchronous active-low reset
//   Rx_IN        : serial line, idle high
//   Prescale     : oversampling ratio (8, 16 or 32), latched at frame start
//   PAR_EN       : parity bit present, latched at frame start
//   PAR_TYP      : 0 even / 1 odd parity, latched at frame start
//   Sampled_bit  : majority-voted bit from the external sampler
//   dat_samp_EN  : sampler enable, high outside IDLE
//   edge_cnt     : oversample edge index within the current bit
//   P_DATA       : received data word
//   data_valid   : one-cycle pulse, good frame
//   par_err      : one-cycle pulse, parity mismatch
//   stp_err      : one-cycle pulse, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int PRESCALE_MAX = DEF_PRESCALE_MAX
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            Rx_IN,
    input  logic [$clog2(PRESCALE_MAX):0]   Prescale,
    input  logic                            PAR_EN,
    input  logic                            PAR_TYP,
    input  logic                            Sampled_bit,
    output logic                            dat_samp_EN,
    output logic [$clog2(PRESCALE_MAX)-1:0] edge_cnt,
    output logic [DATA_WIDTH-1:0]           P_DATA,
    output logic                            data_valid,
    output logic                            par_err,
    output logic                            stp_err
);

    localparam int PW = $clog2(PRESCALE_MAX) + 1;
    localparam int EW = $clog2(PRESCALE_MAX);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [PW-1:0]   r_prescale;
    logic            r_par_en;
    logic            r_par_typ;
    logic            r_parity;
    logic            r_par_fail;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic            r_data_valid;
    logic            r_par_err;
    logic            r_stp_err;

    logic            w_active;
    logic            w_start_det;
    logic            w_bit_end;
    logic            w_bit_clr;
    logic            w_bit_inc;
    logic [BW-1:0]   w_bit_cnt;
    logic            w_last_bit;

    assign w_active    = (r_state != IDLE);
    assign w_start_det = (r_state == IDLE) && !Rx_IN;
    assign w_last_bit  = (w_bit_cnt == BW'(DATA_WIDTH - 1));

    uart_rx_edge_bit_cnt #(
        .PW (PW),
        .EW (EW),
        .BW (BW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_active),
        .i_prescale (r_prescale),
        .i_bit_clr  (w_bit_clr),
        .i_bit_inc  (w_bit_inc),
        .o_edge_cnt (edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_end  (w_bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_bit_clr    = 1'b0;
        w_bit_inc    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!Rx_IN) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_bit_end) begin
                    // A high start bit at its decision point is a line glitch.
                    if (Sampled_bit) begin
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DATA;
                        w_bit_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_bit_end) begin
                    if (w_last_bit) begin
                        w_state_next = r_par_en ? PARITY : STOP;
                    end else begin
                        w_bit_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_bit_end) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale   <= '0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_parity     <= 1'b0;
            r_par_fail   <= 1'b0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
            // Frame configuration is frozen for the whole frame.
            if (w_start_det) begin
                r_prescale <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_parity   <= 1'b0;
                r_par_fail <= 1'b0;
            end
            if (w_bit_end) begin
                case (r_state)
                    DATA: begin
                        // Written in place so P_DATA keeps the previous word
                        // until the next frame's first data bit lands.
                        r_p_data[w_bit_cnt] <= Sampled_bit;
                        r_parity            <= r_parity ^ Sampled_bit;
                    end
                    PARITY: begin
                        r_par_fail <= ((r_parity ^ (r_par_typ == PAR_ODD)) != Sampled_bit);
                    end
                    STOP: begin
                        r_data_valid <= Sampled_bit && !r_par_fail;
                        r_par_err    <= r_par_fail;
                        r_stp_err    <= !Sampled_bit;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign dat_samp_EN = w_active;
    assign P_DATA      = r_p_data;
    assign data_valid  = r_data_valid;
    assign par_err     = r_par_err;
    assign stp_err     = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Rx_IN = 1'b1;
    logic [5:0] Prescale = 6'd8;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       Sampled_bit = 1'b1;
    logic       dat_samp_EN;
    logic [4:0] edge_cnt;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    always #5 clk = ~clk;

    uart_rx_ctrl #(
        .DATA_WIDTH   (8),
        .PRESCALE_MAX (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Rx_IN       (Rx_IN),
        .Prescale    (Prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .Sampled_bit (Sampled_bit),
        .dat_samp_EN (dat_samp_EN),
        .edge_cnt    (edge_cnt),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] flags;   // {data_valid, par_err, stp_err}
        logic [7:0] data;
        int         at;      // cycle count at which the pulse must be seen
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    // Monitor: every output pulse is matched against the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (data_valid || par_err || stp_err) begin
            $display("rx pulse dv=%0b pe=%0b se=%0b P_DATA=%02h cyc=%0d",
                     data_valid, par_err, stp_err, P_DATA, cyc);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse act=%b%b%b req=none", data_valid, par_err, stp_err);
            end else begin
                e = sb.pop_front();
                chk("flags", {29'd0, data_valid, par_err, stp_err}, {29'd0, e.flags});
                chk("P_DATA", {24'd0, P_DATA}, {24'd0, e.data});
                chk("latency", cyc, e.at);
            end
        end
    end

    // Edge-count tracking used while stepping a frame.
    int j = 0;
    int edge_pre = 8;
    bit edge_on = 1'b0;
    int edge_bad = 0;

    task automatic tick();
        @(negedge clk);
        j++;
        if (edge_on && (edge_cnt !== 5'((j - 1) % edge_pre))) edge_bad++;
    endtask

    task automatic drive_bit(input logic v, input int n);
        Rx_IN = v;
        Sampled_bit = v;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle(input int n);
        Rx_IN = 1'b1;
        Sampled_bit = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    // Start bit held pre+1 edges (detect edge + full START bit), then each bit pre edges.
    task automatic send_frame(input int pre, input logic pen, input logic ptyp,
                              input logic [7:0] d, input logic bad_par, input logic stop_bit,
                              input int abort_bits, input bit chk_edge, input bit scramble,
                              input logic [2:0] flags);
        logic pb;
        int   n;
        exp_t e;
        pb = (^d) ^ ptyp ^ bad_par;
        n  = (pre + 1) + 8 * pre + (pen ? pre : 0) + pre;
        $display("send frame data=%02h pre=%0d pen=%0b ptyp=%0b stop=%0b", d, pre, pen, ptyp, stop_bit);
        if (abort_bits < 0) begin
            e.flags = flags;
            e.data  = d;
            e.at    = cyc + n;
            sb.push_back(e);
        end
        Prescale = 6'(pre);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        j        = 0;
        edge_pre = pre;
        edge_on  = chk_edge;
        Rx_IN = 1'b0;
        Sampled_bit = 1'b0;
        tick();
        if (scramble) begin
            Prescale = 6'd16;
            PAR_EN   = ~pen;
            PAR_TYP  = ~ptyp;
        end
        for (int k = 0; k < pre; k++) tick();
        for (int i = 0; i < 8; i++) begin
            if (abort_bits == i) begin
                edge_on = 1'b0;
                return;
            end
            drive_bit(d[i], pre);
        end
        if (pen) drive_bit(pb, pre);
        drive_bit(stop_bit, pre);
        edge_on = 1'b0;
        Rx_IN = 1'b1;
        Sampled_bit = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_outputs", {21'd0, dat_samp_EN, edge_cnt, data_valid, par_err, stp_err}, 32'd0);
        chk("rst_pdata", {24'd0, P_DATA}, 32'd0);
        rst_n = 1'b1;
        idle(3);

        // Prescale 8, no parity, good frame.
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1, 1'b0, 1'b0, 3'b100);
        idle(3);
        // Prescale 16, even parity, wrong parity bit (1) then correct (0).
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, -1, 1'b0, 1'b0, 3'b010);
        idle(3);
        send_frame(16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, -1, 1'b0, 1'b0, 3'b100);
        idle(3);
        // Prescale 32, stop bit low; edge_cnt sequence checked every cycle.
        edge_bad = 0;
        send_frame(32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, -1, 1'b1, 1'b0, 3'b001);
        chk("edge_seq_p32", edge_bad, 0);
        idle(3);

        // Start glitch: low for 2 cycles, aborted at START bit-end.
        $display("send glitch pre=8");
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        j = 0;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 6);
        chk("glitch_en_before", {31'd0, dat_samp_EN}, 32'd1);
        chk("glitch_edge", {27'd0, edge_cnt}, 32'd7);
        tick();
        chk("glitch_en_after", {31'd0, dat_samp_EN}, 32'd0);
        chk("glitch_pdata", {24'd0, P_DATA}, 32'hFF);
        idle(3);

        // Back-to-back frames; config inputs scrambled mid-frame on the first.
        send_frame(8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1, -1, 1'b0, 1'b1, 3'b100);
        send_frame(8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1, -1, 1'b0, 1'b0, 3'b100);
        idle(4);

        // Reset mid-DATA of 0x55, then a clean odd-parity 0x66 frame.
        send_frame(16, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1, 3, 1'b0, 1'b0, 3'b000);
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {21'd0, dat_samp_EN, edge_cnt, data_valid, par_err, stp_err}, 32'd0);
        chk("midrst_pdata", {24'd0, P_DATA}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        send_frame(16, 1'b1, 1'b1, 8'h66, 1'b0, 1'b1, -1, 1'b0, 1'b0, 3'b100);
        idle(5);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
